// File: rtl/turf_axis_mmreq_gen.sv
// rtl/turf_axis_mmreq_gen.sv - TURF mmreq initiator: serializes one command as a two-word request and checks the two-word response
module turf_axis_mmreq_gen #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [27:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  stray_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_H,
        S_REQ_D,
        S_RSP_H,
        S_RSP_D,
        S_DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state_q;
    logic        run_q;
    logic [31:0] hdr_q;
    logic [31:0] wdat_q;
    logic [31:0] m_tdata_q;
    logic        m_tvalid_q;
    logic [31:0] rsp_dat_q;
    logic        rsp_err_q;
    logic        rsp_valid_q;
    logic        hdr_bad_q;
    logic [15:0] timer_q;
    logic [7:0]  stray_q;
    logic [31:0] cmd_hdr;
    logic        timed_out;

    assign cmd_hdr   = {cmd_wr, 3'b000, cmd_adr};
    // >= rather than ==: a header beat that wins at the limit leaves RSP_D already past it
    assign timed_out = (timer_q >= TIMEOUT_W);

    // run_q keeps both ready outputs low while reset is held
    assign cmd_ready     = run_q && (state_q == S_IDLE);
    assign s_axis_tready = run_q && (state_q == S_IDLE || state_q == S_RSP_H || state_q == S_RSP_D);

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_dat       = rsp_dat_q;
    assign rsp_err       = rsp_err_q;
    assign stray_count   = stray_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            hdr_q       <= 32'h0;
            wdat_q      <= 32'h0;
            m_tdata_q   <= 32'h0;
            m_tvalid_q  <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            hdr_bad_q   <= 1'b0;
            timer_q     <= 16'h0;
            stray_q     <= 8'h0;
        end else begin
            run_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run_q && s_axis_tvalid && stray_q != 8'hFF) begin
                        stray_q <= stray_q + 8'd1;
                    end
                    if (run_q && cmd_valid) begin
                        hdr_q      <= cmd_hdr;
                        wdat_q     <= cmd_wr ? cmd_dat : 32'h0;
                        m_tdata_q  <= cmd_hdr;
                        m_tvalid_q <= 1'b1;
                        state_q    <= S_REQ_H;
                    end
                end
                S_REQ_H: begin
                    if (m_axis_tready) begin
                        m_tdata_q <= wdat_q;
                        state_q   <= S_REQ_D;
                    end
                end
                S_REQ_D: begin
                    if (m_axis_tready) begin
                        m_tvalid_q <= 1'b0;
                        timer_q    <= 16'h0;
                        state_q    <= S_RSP_H;
                    end
                end
                S_RSP_H: begin
                    timer_q <= timer_q + 16'd1;
                    if (s_axis_tvalid) begin
                        hdr_bad_q <= (s_axis_tdata != hdr_q);
                        state_q   <= S_RSP_D;
                    end else if (timed_out) begin
                        rsp_dat_q   <= 32'hFFFF_FFFF;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_RSP_D: begin
                    timer_q <= timer_q + 16'd1;
                    if (s_axis_tvalid) begin
                        rsp_dat_q   <= s_axis_tdata;
                        rsp_err_q   <= hdr_bad_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (timed_out) begin
                        rsp_dat_q   <= 32'hFFFF_FFFF;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_turf_axis_mmreq_gen.sv
// tb/tb_turf_axis_mmreq_gen.sv - self-checking bench for turf_axis_mmreq_gen
module tb_turf_axis_mmreq_gen;
    localparam int TO = 16;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [27:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  stray_count;

    int checks = 0;
    int errors = 0;
    int exp_stray = 0;

    turf_axis_mmreq_gen #(.TIMEOUT(TO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .stray_count(stray_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference: expected {err, data} of a completed transaction
    function automatic logic [32:0] model_rsp(input logic wr, input logic [27:0] adr, input logic send,
                                              input int rdelay, input logic [31:0] r0, input logic [31:0] r1);
        logic [31:0] h;
        h = {wr, 3'b000, adr};
        if (!send || rdelay > TO) return {1'b1, 32'hFFFF_FFFF};
        return {(r0 != h), r1};
    endfunction

    // Reference: cycle of rsp_valid counted from command acceptance
    function automatic int model_valid_cycle(input int stall, input logic send, input int rdelay);
        int req1;
        req1 = 2 + 2 * stall;
        if (!send || rdelay > TO) return req1 + 1 + TO + 1;
        return req1 + 3 + rdelay;
    endfunction

    // Drives one command and plays both stream partners; returns at the rsp_valid cycle.
    task automatic do_txn(input logic wr, input logic [27:0] adr, input logic [31:0] dat, input int stall,
                          input logic send, input logic [31:0] r0, input logic [31:0] r1, input int rdelay,
                          output int acc_wait, output int t0, output int t1, output int tv,
                          output logic [31:0] q0, output logic [31:0] q1,
                          output logic [31:0] odat, output logic oerr, output logic stable);
        int cyc, nbeat, rbeat, wcnt, rwait;
        logic [31:0] held;
        logic held_v;
        acc_wait = 0; t0 = -1; t1 = -1; tv = -1; q0 = 'x; q1 = 'x; odat = 'x; oerr = 1'bx;
        stable = 1'b1; cyc = 0; nbeat = 0; rbeat = 0; wcnt = 0; rwait = rdelay; held = '0; held_v = 1'b0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_adr = adr; cmd_dat = dat;
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b0;
        while (!cmd_ready && acc_wait < 50) begin
            @(posedge aclk); @(negedge aclk); acc_wait++;
        end
        for (int k = 0; k < 400; k++) begin
            if (cyc == 1) begin
                cmd_valid = 1'b0; cmd_wr = 1'($urandom); cmd_adr = 28'($urandom); cmd_dat = $urandom;
            end
            m_axis_tready = m_axis_tvalid && (wcnt >= stall);
            s_axis_tvalid = 1'b0;
            if (nbeat == 2 && send && rbeat < 2) begin
                if (rwait == 0) begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata = (rbeat == 0) ? r0 : r1;
                end else begin
                    rwait--;
                end
            end
            if (rsp_valid) begin
                tv = cyc; odat = rsp_dat; oerr = rsp_err;
                break;
            end
            if (m_axis_tvalid) begin
                if (held_v && m_axis_tdata !== held) stable = 1'b0;
                held = m_axis_tdata; held_v = 1'b1;
                if (m_axis_tready) begin
                    if (nbeat == 0) begin q0 = m_axis_tdata; t0 = cyc; end
                    else begin q1 = m_axis_tdata; t1 = cyc; end
                    nbeat++; wcnt = 0; held_v = 1'b0;
                end else begin
                    wcnt++;
                end
            end
            if (s_axis_tvalid && s_axis_tready) rbeat++;
            @(posedge aclk); @(negedge aclk); cyc++;
        end
        cmd_valid = 1'b0; m_axis_tready = 1'b0; s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_adr = '0; cmd_dat = '0;
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        repeat (3) @(negedge aclk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b exp 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h exp 0", m_axis_tdata); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b exp 0", s_axis_tready); end
        checks++; if ({rsp_valid, rsp_err, rsp_dat} !== 34'h0) begin errors++; $display("FAIL rst_rsp: got %b %b %h exp 0 0 0", rsp_valid, rsp_err, rsp_dat); end
        checks++; if (stray_count !== 8'd0) begin errors++; $display("FAIL rst_stray: got %0d exp 0", stray_count); end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++; if (cmd_ready !== 1'b1 || s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b %b exp 1 1", cmd_ready, s_axis_tready); end
    endtask

    task automatic test_write_min_latency();
        int aw, t0, t1, tv; logic [31:0] q0, q1, od; logic oe, st;
        do_txn(1'b1, 28'h0000010, 32'hCAFEBABE, 0, 1'b1, 32'h80000010, 32'hCAFEBABE, 0, aw, t0, t1, tv, q0, q1, od, oe, st);
        checks++; if (q0 !== 32'h80000010 || t0 !== 1) begin errors++; $display("FAIL wr_hdr: got %h @%0d exp 80000010 @1", q0, t0); end
        checks++; if (q1 !== 32'hCAFEBABE || t1 !== 2) begin errors++; $display("FAIL wr_data: got %h @%0d exp cafebabe @2", q1, t1); end
        checks++; if (tv !== 5) begin errors++; $display("FAIL wr_latency: got %0d exp 5", tv); end
        checks++; if (od !== 32'hCAFEBABE || oe !== 1'b0) begin errors++; $display("FAIL wr_rsp: got %h err %b exp cafebabe err 0", od, oe); end
        @(negedge aclk);
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_pulse_end: got valid %b ready %b exp 0 1", rsp_valid, cmd_ready); end
        checks++; if (rsp_dat !== 32'hCAFEBABE) begin errors++; $display("FAIL wr_rsp_hold: got %h exp cafebabe", rsp_dat); end
    endtask

    task automatic test_read_backpressure();
        int aw, t0, t1, tv; logic [31:0] q0, q1, od; logic oe, st;
        do_txn(1'b0, 28'h0000004, 32'h12345678, 3, 1'b1, 32'h00000004, 32'h54555246, 0, aw, t0, t1, tv, q0, q1, od, oe, st);
        checks++; if (q0 !== 32'h00000004 || q1 !== 32'h0) begin errors++; $display("FAIL rd_words: got %h %h exp 00000004 00000000", q0, q1); end
        checks++; if (t0 !== 4 || t1 !== 8) begin errors++; $display("FAIL rd_beat_cycles: got %0d %0d exp 4 8", t0, t1); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL rd_stable: got %b exp 1", st); end
        checks++; if (od !== 32'h54555246 || oe !== 1'b0 || tv !== 11) begin errors++; $display("FAIL rd_rsp: got %h err %b @%0d exp 54555246 err 0 @11", od, oe, tv); end
    endtask

    task automatic test_hdr_mismatch();
        int aw, t0, t1, tv; logic [31:0] q0, q1, od; logic oe, st;
        @(negedge aclk);
        do_txn(1'b0, 28'h0000004, 32'h0, 0, 1'b1, 32'h00000008, 32'hA5A5_0001, 0, aw, t0, t1, tv, q0, q1, od, oe, st);
        checks++; if (od !== 32'hA5A50001 || oe !== 1'b1 || tv !== 5) begin errors++; $display("FAIL hdr_bad: got %h err %b @%0d exp a5a50001 err 1 @5", od, oe, tv); end
    endtask

    task automatic test_timeout_stray();
        int aw, t0, t1, tv; logic [31:0] q0, q1, od; logic oe, st;
        @(negedge aclk);
        do_txn(1'b0, 28'h0000020, 32'h0, 0, 1'b0, 32'h0, 32'h0, 0, aw, t0, t1, tv, q0, q1, od, oe, st);
        checks++; if (tv - (t1 + 1) !== TO + 1) begin errors++; $display("FAIL to_latency: got %0d exp %0d", tv - (t1 + 1), TO + 1); end
        checks++; if (od !== 32'hFFFFFFFF || oe !== 1'b1) begin errors++; $display("FAIL to_rsp: got %h err %b exp ffffffff err 1", od, oe); end
        @(negedge aclk);
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h00000020;
        @(negedge aclk);
        s_axis_tdata = 32'h11112222;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        exp_stray = exp_stray + 2;
        @(negedge aclk);
        checks++; if (stray_count !== 8'(exp_stray)) begin errors++; $display("FAIL to_stray: got %0d exp %0d", stray_count, exp_stray); end
        do_txn(1'b1, 28'h0ABCDEF, 32'h0BADF00D, 1, 1'b1, 32'h80ABCDEF, 32'h0BADF00D, 2, aw, t0, t1, tv, q0, q1, od, oe, st);
        checks++; if (od !== 32'h0BADF00D || oe !== 1'b0 || tv !== model_valid_cycle(1, 1'b1, 2)) begin errors++; $display("FAIL to_recover: got %h err %b @%0d exp 0badf00d err 0 @%0d", od, oe, tv, model_valid_cycle(1, 1'b1, 2)); end
    endtask

    task automatic test_stray_saturate();
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            s_axis_tdata = $urandom;
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        exp_stray = (exp_stray + 300 > 255) ? 255 : exp_stray + 300;
        @(negedge aclk);
        checks++; if (stray_count !== 8'(exp_stray)) begin errors++; $display("FAIL stray_sat: got %0d exp %0d", stray_count, exp_stray); end
    endtask

    task automatic test_reset_mid();
        int aw, t0, t1, tv, pulses; logic [31:0] q0, q1, od; logic oe, st;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_adr = 28'h0000040; cmd_dat = 32'h01020304;
        @(negedge aclk);
        cmd_valid = 1'b0; m_axis_tready = 1'b1;
        @(negedge aclk);
        m_axis_tready = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h01020304) begin errors++; $display("FAIL mid_in_req_d: got %b %h exp 1 01020304", m_axis_tvalid, m_axis_tdata); end
        aresetn = 1'b0;
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got tvalid %b ready %b valid %b exp 0 0 0", m_axis_tvalid, cmd_ready, rsp_valid); end
        pulses = 0;
        repeat (2) begin @(negedge aclk); if (rsp_valid) pulses++; end
        aresetn = 1'b1;
        exp_stray = 0;
        repeat (30) begin @(negedge aclk); if (rsp_valid || m_axis_tvalid) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_no_pulse: got %0d exp 0", pulses); end
        checks++; if (stray_count !== 8'd0) begin errors++; $display("FAIL mid_stray_clr: got %0d exp 0", stray_count); end
        do_txn(1'b1, 28'h0000040, 32'hDEADBEEF, 0, 1'b1, 32'h80000040, 32'hDEADBEEF, 0, aw, t0, t1, tv, q0, q1, od, oe, st);
        checks++; if (q0 !== 32'h80000040 || q1 !== 32'hDEADBEEF || od !== 32'hDEADBEEF || oe !== 1'b0 || tv !== 5) begin errors++; $display("FAIL mid_recover: got %h %h %h err %b @%0d", q0, q1, od, oe, tv); end
    endtask

    task automatic test_back_to_back();
        int aw, t0, t1, tv; logic [31:0] q0, q1, od; logic oe, st;
        @(negedge aclk);
        do_txn(1'b0, 28'h0000100, 32'h0, 0, 1'b1, 32'h00000100, 32'h00C0FFEE, 0, aw, t0, t1, tv, q0, q1, od, oe, st);
        do_txn(1'b1, 28'h0000104, 32'h77665544, 0, 1'b1, 32'h80000104, 32'h77665544, 0, aw, t0, t1, tv, q0, q1, od, oe, st);
        checks++; if (aw !== 1) begin errors++; $display("FAIL b2b_accept: got wait %0d exp 1", aw); end
        checks++; if (od !== 32'h77665544 || oe !== 1'b0 || tv !== 5) begin errors++; $display("FAIL b2b_rsp: got %h err %b @%0d exp 77665544 err 0 @5", od, oe, tv); end
    endtask

    task automatic test_random();
        int aw, t0, t1, tv, stall, rdelay; logic [31:0] q0, q1, od, dat, r0, r1, h; logic oe, st, wr, bad;
        logic [27:0] adr; logic [32:0] exp;
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(1, 3)) @(negedge aclk);
            wr = 1'($urandom); adr = 28'($urandom); dat = $urandom;
            stall = $urandom_range(0, 2);
            rdelay = (n == 0) ? TO : $urandom_range(0, TO);
            h = {wr, 3'b000, adr};
            bad = ($urandom_range(0, 3) == 0);
            r0 = bad ? (h ^ (32'h1 << $urandom_range(0, 31))) : h;
            r1 = wr ? dat : $urandom;
            do_txn(wr, adr, dat, stall, 1'b1, r0, r1, rdelay, aw, t0, t1, tv, q0, q1, od, oe, st);
            exp = model_rsp(wr, adr, 1'b1, rdelay, r0, r1);
            checks++; if (q0 !== h || q1 !== (wr ? dat : 32'h0) || st !== 1'b1) begin errors++; $display("FAIL rnd_req[%0d]: got %h %h stable %b exp %h %h", n, q0, q1, st, h, wr ? dat : 32'h0); end
            checks++; if ({oe, od} !== exp) begin errors++; $display("FAIL rnd_rsp[%0d]: got %b %h exp %b %h", n, oe, od, exp[32], exp[31:0]); end
            checks++; if (tv !== model_valid_cycle(stall, 1'b1, rdelay) || aw !== 0) begin errors++; $display("FAIL rnd_timing[%0d]: got %0d wait %0d exp %0d wait 0", n, tv, aw, model_valid_cycle(stall, 1'b1, rdelay)); end
        end
        @(negedge aclk);
        checks++; if (stray_count !== 8'(exp_stray)) begin errors++; $display("FAIL rnd_stray: got %0d exp %0d", stray_count, exp_stray); end
    endtask

    initial begin
        test_reset();
        test_write_min_latency();
        test_read_backpressure();
        test_hdr_mismatch();
        test_timeout_stray();
        test_stray_saturate();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
